// File: rtl/mips_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control_if
//   Bundle between the multicycle MIPS control FSM and its datapath.
//   Instruction fields and the memory handshake come from the datapath.
//   Mux selects, write strobes, the ULA opcode and status go back to it.
//
//   master : the control FSM (reads OP/Funct/mem_ready, drives the controls)
//   slave  : the datapath side (drives OP/Funct/mem_ready, reads the controls)
//
//   Signals: OP[5:0], Funct[5:0], mem_ready,
//            PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//            RegDst, RegWrite, ULASrcA, ULASrcB[1:0], PCSrc[1:0],
//            ULAControl[ULA_CTRL_W-1:0], mem_err, state_o[3:0]
//            illegal_op (only when ILLEGAL_TRAP_EN is defined)
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if #(
  parameter int ULA_CTRL_W = 3
);
  logic [5:0]            OP;
  logic [5:0]            Funct;
  logic                  mem_ready;
  logic                  PCWrite;
  logic                  Branch;
  logic                  IorD;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  MemtoReg;
  logic                  RegDst;
  logic                  RegWrite;
  logic                  ULASrcA;
  logic [1:0]            ULASrcB;
  logic [1:0]            PCSrc;
  logic [ULA_CTRL_W-1:0] ULAControl;
  logic                  mem_err;
  logic [3:0]            state_o;
`ifdef ILLEGAL_TRAP_EN
  logic                  illegal_op;

  modport master (
    input  OP, Funct, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ULASrcA, ULASrcB, PCSrc, ULAControl,
           mem_err, state_o, illegal_op
  );

  modport slave (
    output OP, Funct, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ULASrcA, ULASrcB, PCSrc, ULAControl,
           mem_err, state_o, illegal_op
  );
`else
  modport master (
    input  OP, Funct, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ULASrcA, ULASrcB, PCSrc, ULAControl,
           mem_err, state_o
  );

  modport slave (
    output OP, Funct, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ULASrcA, ULASrcB, PCSrc, ULAControl,
           mem_err, state_o
  );
`endif
endinterface

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//   Moore control FSM for a multicycle MIPS datapath with a shared ULA and a
//   unified memory. Supports add/sub/and/or/slt, lw, sw, beq, addi, andi,
//   ori and j. Every memory state waits on mem_ready. A wait of WAIT_MAX
//   cycles aborts the instruction, returns to FETCH and sets the sticky
//   mem_err flag.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     ctrl   mips_multicycle_control_if.master (OP/Funct/mem_ready in,
//            datapath controls, mem_err and state_o out)
//
//   Parameters:
//     ULA_CTRL_W  width of ULAControl (>= 3, codes are zero-extended)
//     WAIT_MAX    memory wait cycles before timeout (1..255)
//
//   Optional macro ILLEGAL_TRAP_EN: an unknown OP or R-type Funct enters
//   TRAP (state 12). TRAP raises illegal_op and stays there until reset.
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int ULA_CTRL_W = 3,
  parameter int WAIT_MAX   = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.master   ctrl
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_IEXEC   = 4'd9;
  localparam logic [3:0] S_IWB     = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP    = 4'd12;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // Last wait count before a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q,  wait_d;
  logic       mem_err_q, mem_err_d;

  logic       mem_state;
  logic       funct_known;
  logic [2:0] funct_ula;

  // R-type function decode. An unknown Funct falls back to add.
  always_comb begin
    funct_known = 1'b1;
    case (ctrl.Funct)
      6'b100000: funct_ula = ULA_ADD;
      6'b100010: funct_ula = ULA_SUB;
      6'b100100: funct_ula = ULA_AND;
      6'b100101: funct_ula = ULA_OR;
      6'b101010: funct_ula = ULA_SLT;
      default: begin
        funct_ula   = ULA_ADD;
        funct_known = 1'b0;
      end
    endcase
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);

  // Next-state, wait counter and timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    wait_d    = '0;
    mem_err_d = mem_err_q;

    case (state_q)
      S_FETCH: if (ctrl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.OP)
          OP_LW, OP_SW:               state_d = S_MEMADR;
          OP_RTYPE:                   state_d = S_EXECUTE;
          OP_BEQ:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
          OP_J:                       state_d = S_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR:  state_d = (ctrl.OP == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ctrl.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (ctrl.mem_ready) state_d = S_FETCH;
      S_EXECUTE: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = funct_known ? S_ALUWB : S_TRAP;
`else
        state_d = S_ALUWB;
`endif
      end
      S_IEXEC:   state_d = S_IWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase

    // Count stalled memory cycles. The counter clears whenever the access
    // completes or the state is not a memory state. On the last allowed
    // stall, the instruction is dropped and control returns to FETCH.
    if (mem_state && !ctrl.mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        mem_err_d = 1'b1;
        state_d   = S_FETCH;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Moore outputs. In FETCH, IRWrite and PCWrite follow mem_ready, so they
  // fire only on the cycle the instruction word actually arrives.
  always_comb begin
    ctrl.PCWrite    = 1'b0;
    ctrl.Branch     = 1'b0;
    ctrl.IorD       = 1'b0;
    ctrl.MemRead    = 1'b0;
    ctrl.MemWrite   = 1'b0;
    ctrl.IRWrite    = 1'b0;
    ctrl.MemtoReg   = 1'b0;
    ctrl.RegDst     = 1'b0;
    ctrl.RegWrite   = 1'b0;
    ctrl.ULASrcA    = 1'b0;
    ctrl.ULASrcB    = 2'b00;
    ctrl.PCSrc      = 2'b00;
    ctrl.ULAControl = ULA_CTRL_W'(ULA_ADD);
`ifdef ILLEGAL_TRAP_EN
    ctrl.illegal_op = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ULASrcB = 2'b01;
        ctrl.IRWrite = ctrl.mem_ready;
        ctrl.PCWrite = ctrl.mem_ready;
      end
      S_DECODE:  ctrl.ULASrcB = 2'b11;
      S_MEMADR: begin
        ctrl.ULASrcA = 1'b1;
        ctrl.ULASrcB = 2'b10;
      end
      S_MEMRD: begin
        ctrl.IorD    = 1'b1;
        ctrl.MemRead = 1'b1;
      end
      S_MEMWB: begin
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.IorD     = 1'b1;
        ctrl.MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.ULASrcA    = 1'b1;
        ctrl.ULAControl = ULA_CTRL_W'(funct_ula);
      end
      S_ALUWB: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.ULASrcA    = 1'b1;
        ctrl.ULAControl = ULA_CTRL_W'(ULA_SUB);
        ctrl.Branch     = 1'b1;
        ctrl.PCSrc      = 2'b01;
      end
      S_IEXEC: begin
        ctrl.ULASrcA = 1'b1;
        ctrl.ULASrcB = 2'b10;
        if (ctrl.OP == OP_ANDI)     ctrl.ULAControl = ULA_CTRL_W'(ULA_AND);
        else if (ctrl.OP == OP_ORI) ctrl.ULAControl = ULA_CTRL_W'(ULA_OR);
      end
      S_IWB:     ctrl.RegWrite = 1'b1;
      S_JUMP: begin
        ctrl.PCSrc   = 2'b10;
        ctrl.PCWrite = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.ULAControl = '0;
        ctrl.illegal_op = 1'b1;
      end
`endif
      default: ;
    endcase

    // A synchronous reset only takes effect at the edge. This gating keeps
    // a half-finished instruction from issuing strobes during the reset
    // cycle itself.
    if (!rst_n) begin
      ctrl.PCWrite  = 1'b0;
      ctrl.Branch   = 1'b0;
      ctrl.MemRead  = 1'b0;
      ctrl.MemWrite = 1'b0;
      ctrl.IRWrite  = 1'b0;
      ctrl.RegWrite = 1'b0;
    end
  end

  assign ctrl.state_o = state_q;
  assign ctrl.mem_err = mem_err_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//   Directed bench for mips_multicycle_control with WAIT_MAX = 4.
//   Inputs change 1 ns after each rising edge. Outputs are checked 1 ns
//   later. The state and the full control word are compared against
//   hand-written per-state vectors.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if #(.ULA_CTRL_W(3)) bus ();

  mips_multicycle_control #(.ULA_CTRL_W(3), .WAIT_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  // Control word:
  // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ULASrcA,ULASrcB[1:0],PCSrc[1:0],ULAControl[2:0]}
  logic [16:0] obs;
  assign obs = {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                bus.ULASrcA, bus.ULASrcB, bus.PCSrc, bus.ULAControl};

  function automatic logic [16:0] pk(
    input logic pcw, br, iord, mr, mw, irw, m2r, rdst, rw, sa,
    input logic [1:0] sb, pcs, input logic [2:0] ula);
    return {pcw, br, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, pcs, ula};
  endfunction

  //                               pcw br io mr mw ir m2 rd rw sa  sb     pcs    ula
  localparam logic [16:0] V_RST   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
  localparam logic [16:0] V_FRDY  = pk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
  localparam logic [16:0] V_FNRDY = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
  localparam logic [16:0] V_DEC   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
  localparam logic [16:0] V_MADR  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
  localparam logic [16:0] V_MRD   = pk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_MWB   = pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_MWR   = pk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_MWRR  = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_ESUB  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b110);
  localparam logic [16:0] V_EADD  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_AWB   = pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_BR    = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110);
  localparam logic [16:0] V_IOR   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b001);
  localparam logic [16:0] V_IWB   = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010);
  localparam logic [16:0] V_JMP   = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010);
`ifdef ILLEGAL_TRAP_EN
  localparam logic [16:0] V_TRAP  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
`endif

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Wait for the outputs to settle, then check state and control word.
  task automatic st(input string tag, input logic [3:0] s, input logic [16:0] c);
    #1;
    check({tag, " state"}, 32'(bus.state_o), 32'(s));
    check({tag, " ctl"},   32'(obs),         32'(c));
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.OP        = 6'b000000;
    bus.Funct     = 6'b000000;

    // Reset held for two edges with memory ready: no strobes.
    go(); st("rst1", 4'd0, V_RST);
    go(); st("rst2", 4'd0, V_RST);
    check("rst mem_err", 32'(bus.mem_err), 32'd0);
    rst_n  = 1'b1;
    bus.OP = 6'b100011;                               // lw
    st("fetch after release", 4'd0, V_FRDY);

    // lw, zero-wait: 0,1,2,3,4.
    go(); st("lw dec",    4'd1, V_DEC);
    go(); st("lw memadr", 4'd2, V_MADR);
    go(); st("lw memrd",  4'd3, V_MRD);
    go(); st("lw memwb",  4'd4, V_MWB);
    go(); bus.OP = 6'b101011;                         // sw
    st("lw done", 4'd0, V_FRDY);

    // sw with three stalls in MEMWR: MemWrite held for four cycles.
    go(); st("sw dec",    4'd1, V_DEC);
    go(); st("sw memadr", 4'd2, V_MADR);
    go(); bus.mem_ready = 1'b0;
    st("sw wr1", 4'd5, V_MWR);
    go(); st("sw wr2", 4'd5, V_MWR);
    go(); st("sw wr3", 4'd5, V_MWR);
    go(); bus.mem_ready = 1'b1;
    st("sw wr4", 4'd5, V_MWR);
    go(); bus.OP = 6'b000000; bus.Funct = 6'b100010; // sub
    st("sw done", 4'd0, V_FRDY);
    check("sw mem_err", 32'(bus.mem_err), 32'd0);

    // R-type sub.
    go(); st("sub dec",   4'd1, V_DEC);
    go(); st("sub exec",  4'd6, V_ESUB);
    go(); st("sub aluwb", 4'd7, V_AWB);
    go(); bus.OP = 6'b000100;                         // beq
    st("sub done", 4'd0, V_FRDY);

    // beq.
    go(); st("beq dec",    4'd1, V_DEC);
    go(); st("beq branch", 4'd8, V_BR);
    go(); bus.OP = 6'b001101;                         // ori
    st("beq done", 4'd0, V_FRDY);

    // ori.
    go(); st("ori dec",   4'd1, V_DEC);
    go(); st("ori iexec", 4'd9, V_IOR);
    go(); st("ori iwb",   4'd10, V_IWB);
    go(); bus.OP = 6'b000010;                         // j
    st("ori done", 4'd0, V_FRDY);

    // j.
    go(); st("j dec",  4'd1, V_DEC);
    go(); st("j jump", 4'd11, V_JMP);
    go(); bus.OP = 6'b101011;                         // sw, to be reset
    st("j done", 4'd0, V_FRDY);

    // Reset in the middle of a stalled store: MemWrite drops at once.
    go(); st("rsw dec",    4'd1, V_DEC);
    go(); st("rsw memadr", 4'd2, V_MADR);
    go(); bus.mem_ready = 1'b0;
    st("rsw wr", 4'd5, V_MWR);
    go(); rst_n = 1'b0;
    st("rsw in reset", 4'd5, V_MWRR);
    go(); st("rsw after edge", 4'd0, V_RST);
    rst_n = 1'b1; bus.mem_ready = 1'b1;
    bus.OP = 6'b000000; bus.Funct = 6'b111111;       // R-type, unknown Funct
    st("rsw release", 4'd0, V_FRDY);

`ifndef ILLEGAL_TRAP_EN
    // Unknown Funct completes as add.
    go(); st("badfn dec",   4'd1, V_DEC);
    go(); st("badfn exec",  4'd6, V_EADD);
    go(); st("badfn aluwb", 4'd7, V_AWB);
    go(); st("badfn done",  4'd0, V_FRDY);
`endif
    bus.OP = 6'b100011;                               // lw, to time out

    // lw with memory never ready: aborts after WAIT_MAX = 4 stalls.
    go(); st("to dec",    4'd1, V_DEC);
    go(); st("to memadr", 4'd2, V_MADR);
    go(); bus.mem_ready = 1'b0;
    st("to rd1", 4'd3, V_MRD);
    go(); st("to rd2", 4'd3, V_MRD);
    go(); st("to rd3", 4'd3, V_MRD);
    go(); st("to rd4", 4'd3, V_MRD);
    check("to mem_err before", 32'(bus.mem_err), 32'd0);
    go(); bus.mem_ready = 1'b1; bus.OP = 6'b111111;  // illegal OP next
    st("to abort", 4'd0, V_FRDY);
    check("to mem_err set", 32'(bus.mem_err), 32'd1);

    // Unknown OP.
    go(); st("badop dec", 4'd1, V_DEC);
    check("badop mem_err sticky", 32'(bus.mem_err), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    go(); st("badop trap", 4'd12, V_TRAP);
    check("badop illegal_op", 32'(bus.illegal_op), 32'd1);
    go(); st("badop trap held", 4'd12, V_TRAP);
`else
    go(); st("badop nop", 4'd0, V_FRDY);
    check("badop mem_err still", 32'(bus.mem_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
